// File: rtl/esp_uart_pkg.sv
// Shared constants and types for the esp_uart link (TX and RX halves).
package esp_uart_pkg;

  localparam int unsigned DefaultClksPerBit = 16;
  localparam int unsigned FifoDepth         = 16;
  localparam int unsigned FifoAw            = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  function automatic logic [FifoAw-1:0] idx_inc(input logic [FifoAw-1:0] idx);
    return idx + FifoAw'(1);
  endfunction

endpackage

// File: rtl/esp_uart_txfifo.sv
// 16x8 transmit FIFO; one slot is sacrificed so full/empty come straight from the indices.
module esp_uart_txfifo
  import esp_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wrdata,
  input  logic       rd_en,
  output logic [7:0] rddata,
  output logic       full,
  output logic       empty
);

  logic [7:0]        mem_q [FifoDepth];
  logic [FifoAw-1:0] wridx_q, wridx_d;
  logic [FifoAw-1:0] rdidx_q, rdidx_d;
  logic              push, pop;

  assign empty  = (wridx_q == rdidx_q);
  assign full   = (idx_inc(wridx_q) == rdidx_q);
  assign rddata = mem_q[rdidx_q];

  // Full is judged on the pre-edge indices, so a same-cycle pop never frees a slot early.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    wridx_d = wridx_q;
    rdidx_d = rdidx_q;
    if (push) wridx_d = idx_inc(wridx_q);
    if (pop)  rdidx_d = idx_inc(rdidx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wridx_q <= '0;
      rdidx_q <= '0;
    end else begin
      wridx_q <= wridx_d;
      rdidx_q <= rdidx_d;
    end
  end

  // Storage needs no reset: clearing the indices discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wridx_q] <= wrdata;
  end

endmodule

// File: rtl/esp_uart_tx.sv
// ESP32 UART transmitter: FIFO-buffered 8N1 serializer, LSB first, gated by CTS at frame start.
module esp_uart_tx
  import esp_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wrdata,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       busy,
  input  logic       esp_cts_n,
  output logic       esp_txd
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             cts_meta_q, cts_sync_q;

  logic       cts_ok;
  logic       pop;
  logic [7:0] head;
  logic       bit_end;
  logic       load_ok;

  esp_uart_txfifo u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wrdata (wrdata),
    .rd_en  (pop),
    .rddata (head),
    .full   (full),
    .empty  (empty)
  );

  // Synchronizer resets to "not clear" so nothing starts before CTS is really seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= esp_cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok  = !cts_sync_q;
  assign bit_end = (baud_cnt_q == BaudLast);
  assign load_ok = !empty && cts_ok;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;

    if (state_q != StIdle) baud_cnt_d = bit_end ? '0 : baud_cnt_q + BaudW'(1);

    unique case (state_q)
      StIdle: begin
        if (load_ok) begin
          pop        = 1'b1;
          shreg_d    = head;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        // Chain straight into the next start bit when allowed, so streams have no idle gap.
        if (bit_end) begin
          if (load_ok) begin
            pop        = 1'b1;
            shreg_d    = head;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
    end
  end

  assign esp_txd = txd_q;
  assign busy    = !empty || (state_q != StIdle);

endmodule
